// File: rtl/ram_port_arb.sv
// ram_port_arb: shares RAM port a between the CPU data bus (m0) and the accelerator (m1).
// Latency: grant is combinational; read data returns one cycle after the grant cycle.
// Backpressure: m0 has fixed priority; m1 takes the port after MAXWAIT consecutive stalls.
module ram_port_arb #(
  parameter int XADR    = 12,
  parameter int MAXWAIT = 8
) (
  input  logic            clk,
  input  logic            rst_n,

  input  logic            m0_req,
  input  logic [3:0]      m0_wen,
  input  logic [XADR-1:0] m0_addr,
  input  logic [31:0]     m0_wdata,
  output logic            m0_gnt,
  output logic            m0_rvalid,
  output logic [31:0]     m0_rdata,

  input  logic            m1_req,
  input  logic [3:0]      m1_wen,
  input  logic [XADR-1:0] m1_addr,
  input  logic [31:0]     m1_wdata,
  output logic            m1_gnt,
  output logic            m1_rvalid,
  output logic [31:0]     m1_rdata,

  output logic [3:0]      ram_wen,
  output logic [XADR-1:0] ram_addr,
  output logic [31:0]     ram_wdata,
  input  logic [31:0]     ram_rdata
);

  localparam int WW = $clog2(MAXWAIT + 1);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_M0   = 2'd1,
    OWN_M1   = 2'd2
  } own_t;

  logic [WW-1:0] wait_cnt;
  logic          starve;
  own_t          rd_own;
  own_t          rd_own_nxt;

  // Grant: m1 takes the port when m0 is idle or m1 has been starved long enough.
  always_comb begin
    m1_gnt = m1_req & (~m0_req | starve);
    m0_gnt = m0_req & ~m1_gnt;
  end

  // RAM request mux; with no grant, park on a harmless read of m0's address.
  always_comb begin
    ram_wen   = 4'b0000;
    ram_addr  = m0_addr;
    ram_wdata = m0_wdata;
    if (m1_gnt) begin
      ram_wen   = m1_wen;
      ram_addr  = m1_addr;
      ram_wdata = m1_wdata;
    end else if (m0_gnt) begin
      ram_wen   = m0_wen;
      ram_addr  = m0_addr;
      ram_wdata = m0_wdata;
    end
  end

  // Count consecutive stalled m1 cycles, saturating; any grant or dropped request restarts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (m1_gnt || !m1_req) begin
      wait_cnt <= '0;
    end else if (wait_cnt != WW'(MAXWAIT)) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Starve flag: raised after a stalled cycle seen at the limit, dropped once m1 is served or leaves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve <= 1'b0;
    end else begin
      starve <= m1_req && !m1_gnt && (wait_cnt >= WW'(MAXWAIT));
    end
  end

  // Next read owner: only a granted access with all byte enables low is a read.
  always_comb begin
    rd_own_nxt = OWN_NONE;
    if (m0_gnt && (m0_wen == 4'b0000)) begin
      rd_own_nxt = OWN_M0;
    end else if (m1_gnt && (m1_wen == 4'b0000)) begin
      rd_own_nxt = OWN_M1;
    end
  end

  // Read owner register; reset discards any in-flight read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_own <= OWN_NONE;
    end else begin
      rd_own <= rd_own_nxt;
    end
  end

  assign m0_rvalid = (rd_own == OWN_M0);
  assign m1_rvalid = (rd_own == OWN_M1);
  assign m0_rdata  = m0_rvalid ? ram_rdata : 32'h0;
  assign m1_rdata  = m1_rvalid ? ram_rdata : 32'h0;

endmodule

// File: doc/ram_port_arb.md
# ram_port_arb

Two-requester arbiter for port a (read/write, byte-enabled) of the main FPGA CPU RAM. It shares that single synchronous port between the CPU data bus (m0) and a hash-accelerator/DMA master (m1). Port b (instruction fetch) is not touched. It uses fixed priority for m0 with a bounded-wait guarantee for m1, and routes the one-cycle-latency read data back to the requester that issued the read.

## Interface
- XADR, 12: RAM word-address width.
- MAXWAIT, 8: number of consecutive stalled cycles after which m1 overrides m0. Legal range is ≥ 1.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- m0_req  in  1  CPU access request; held with its fields stable until m0_gnt.
- m0_wen  in  4  CPU byte write enables; 0000 means read.
- m0_addr  in  XADR  CPU word address.
- m0_wdata  in  32  CPU write data.
- m0_gnt  out  1  CPU access issued this cycle (combinational).
- m0_rvalid  out  1  CPU read data valid on m0_rdata.
- m0_rdata  out  32  CPU read data.
- m1_req, m1_wen, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same as m0, for the accelerator.
- ram_wen  out  4  to RAM wen0.
- ram_addr  out  XADR  to RAM addr0.
- ram_wdata  out  32  to RAM wdata0.
- ram_rdata  in  32  from RAM rdata0, valid the cycle after address issue.

## Operation
- **Grant (combinational, per cycle):**
  - m1 wins when m1_req is high and either m0_req is low or starve is set.
  - Otherwise m0 wins when m0_req is high.
  - At most one gnt is high per cycle.
- **starve:** registered flag, set when wait_cnt ≥ MAXWAIT.
- **wait_cnt:** width $clog2(MAXWAIT+1), reset value 0.
  - Increments when m1_req=1 and m1_gnt=0, saturating at MAXWAIT.
  - Clears to 0 when m1_gnt=1 or m1_req=0.
- **RAM mux:**
  - Granted master's wen/addr/wdata drive the ram_* outputs.
  - With no grant: ram_wen=0000, ram_addr=m0_addr, ram_wdata=m0_wdata. This is a harmless read whose data is discarded.
- **Read return:**
  - Registered owner state rd_own ∈ {NONE, M0, M1}.
  - rd_own ← M0 if m0_gnt and m0_wen=0000; ← M1 if m1_gnt and m1_wen=0000; else ← NONE.
  - mX_rvalid = (rd_own==X).
  - mX_rdata = ram_rdata when mX_rvalid, else 32'h0.
- **Writes:** no response beyond gnt; the write completes at the edge ending the grant cycle.
- **Partial-write-with-read:** any nonzero wen is a write; no read data is returned.

## Timing
- **Reset (rst_n=0, asynchronous):**
  - wait_cnt=0, starve=0, rd_own=NONE, m0_rvalid=m1_rvalid=0, mX_rdata=0.
  - Grants and ram_* follow the inputs combinationally, so drive req low during reset.
- **Latency:** request issued in grant cycle N; read data and rvalid appear in cycle N+1. This gives one access per cycle of throughput, back-to-back, with no bubbles.
- **Handshake:** a requester may change fields only in the cycle after its gnt. It may deassert req without a grant; the abandoned request has no side effects.
- **Starvation bound:** with m0_req continuously high, m1 is granted no later than MAXWAIT+1 cycles after m1_req rises. The grant in that cycle goes to m1 and m0 stalls exactly one cycle; wait_cnt then restarts from 0.
- **Simultaneous read-after-write to the same address by different masters:** grant order decides. A later read sees the earlier write because the RAM is read-old-data, the write lands at the end of cycle N, and the read is issued at N+1 or later.
- **Reset mid-read:** rvalid for the in-flight read is dropped and never reissued.

## Test plan
- **Reset:** hold rst_n=0 with m0/m1 reads pending, release → rvalids 0 until the first post-reset grant. Asynchronous assert mid-read clears m0_rvalid within the same cycle.
- **m0 write then read:** m0 write 0xDEADBEEF with wen=1111 to addr 0x010, next cycle read 0x010 → m0_rvalid high 1 cycle after the read gnt, m0_rdata=0xDEADBEEF, m1_rvalid=0.
- **Byte enables:** with mem[0x020]=0x11223344, m1 write wen=0100 wdata=0x00AA0000 → read returns 0x11AA3344.
- **Contention, MAXWAIT=8:** m0_req held high with reads streaming, m1 read of 0x030 asserted at cycle 0 → m1_gnt first high at cycle 9, m0_gnt low only that cycle, m1_rvalid at cycle 10, m0 grants resume at cycle 10.
- **Idle m0:** m1 streams 16 reads of consecutive addresses → m1_gnt every cycle, 16 rvalid pulses with matching data, wait_cnt stays 0.
- **Abandon:** m1_req high 3 cycles under m0 load then dropped → no m1_gnt, wait_cnt returns to 0, and a later m1 request waits the full MAXWAIT again.
